// File: rtl/reg_bus_master_pkg.sv
// reg_bus_master_pkg: shared register-bus constants and master FSM encoding
package reg_bus_master_pkg;

    localparam int         BUS_ADDR_W   = 7;
    localparam int         CMD_RW_BIT   = 7;
    localparam logic [7:0] BUS_ACK_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_LEN  = 3'd1,
        GET_DATA = 3'd2,
        WR_STB   = 3'd3,
        RD_ADDR  = 3'd4,
        RD_WAIT  = 3'd5,
        SEND     = 3'd6
    } state_t;

endpackage

// File: rtl/reg_bus_master_byte_timeout_counter.sv
// byte_timeout_counter: counts idle cycles while running; o_expired on the last allowed cycle
module byte_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign o_expired = i_run && cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || !i_run)
            cnt <= '0;
        else if (!o_expired)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: decodes host read/write burst commands into register-bus cycles
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int         ADDR_W         = BUS_ADDR_W,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_BYTE       = BUS_ACK_BYTE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_data,
    input  logic [7:0]        i_data,
    output logic              o_busy,
    output logic              o_timeout
);

    state_t            state, state_nx;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        cnt;
    logic              rx_acc, tmo_run, tmo_exp, tmo_abort;

    assign rx_acc    = i_rx_valid && o_rx_ready;
    assign tmo_run   = state == GET_LEN || state == GET_DATA;
    assign tmo_abort = tmo_run && tmo_exp && !rx_acc;

    byte_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_run     (tmo_run),
        .i_clear   (rx_acc),
        .o_expired (tmo_exp)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = rx_acc ? GET_LEN : IDLE;
            GET_LEN:  state_nx = rx_acc ? (rw ? GET_DATA : RD_ADDR) : tmo_exp ? IDLE : GET_LEN;
            GET_DATA: state_nx = rx_acc ? WR_STB : tmo_exp ? IDLE : GET_DATA;
            WR_STB:   state_nx = cnt == 9'd1 ? SEND : GET_DATA;
            RD_ADDR:  state_nx = RD_WAIT;
            RD_WAIT:  state_nx = SEND;
            SEND:     state_nx = !i_tx_ready ? SEND : (!rw && cnt != 9'd1) ? RD_ADDR : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_rx_ready = !i_rst && (state == IDLE || state == GET_LEN || state == GET_DATA);
        o_wr       = state == WR_STB;
        o_tx_valid = state == SEND;
        o_busy     = state != IDLE;
    end

    // o_addr is loaded on entry to RD_ADDR so the responder sees it during RD_ADDR itself
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rw        <= 1'b0;
            addr      <= '0;
            cnt       <= '0;
            o_addr    <= '0;
            o_data    <= '0;
            o_tx_data <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= tmo_abort;
            if (state == IDLE && rx_acc) begin
                rw   <= i_rx_data[CMD_RW_BIT];
                addr <= i_rx_data[ADDR_W-1:0];
            end
            if (state == GET_LEN && rx_acc)
                cnt <= {1'b0, i_rx_data} + 9'd1;
            if (state == GET_DATA && rx_acc) begin
                o_data <= i_rx_data;
                o_addr <= addr;
            end
            if (state == WR_STB || (state == SEND && i_tx_ready && !rw)) begin
                addr <= addr + ADDR_W'(1);
                cnt  <= cnt - 9'd1;
            end
            if (state == WR_STB)
                o_tx_data <= ACK_BYTE;
            if (state_nx == RD_ADDR)
                o_addr <= state == SEND ? addr + ADDR_W'(1) : addr;
            if (state == RD_WAIT)
                o_tx_data <= i_data;
        end
    end

endmodule
